// File: rtl/cblock_cfg_if.sv
// cblock_cfg_if: serial configuration chain handshake between the config controller and a connection block
interface cblock_cfg_if;
    logic cfg_si;
    logic cfg_valid;
    logic cfg_last;
    logic cfg_ready;
    logic cfg_done;
    logic cfg_err;
    logic cfg_rb;
    logic cfg_so;
    modport master (
        output cfg_si, cfg_valid, cfg_last, cfg_rb,
        input  cfg_ready, cfg_done, cfg_err, cfg_so
    );
    modport slave (
        input  cfg_si, cfg_valid, cfg_last, cfg_rb,
        output cfg_ready, cfg_done, cfg_err, cfg_so
    );
endinterface

// File: rtl/cblock_cfg.sv
// cblock_cfg: parametrised connection block with serial shadow/active config chain; CBLOCK_READBACK_EN adds ACT readback on cfg_so
module cblock_cfg #(
    parameter int H_TRACKS = 3,
    parameter int V_TRACKS = 3,
    parameter int SEGS     = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [H_TRACKS-1:0] left_i,
    input  logic [V_TRACKS-1:0] up_i,
    output logic [H_TRACKS-1:0] right_o,
    output logic [V_TRACKS-1:0] down_o,
    cblock_cfg_if.slave         cfg
);
    localparam int HS       = H_TRACKS * SEGS;
    localparam int VS       = V_TRACKS * SEGS;
    localparam int HV       = H_TRACKS * V_TRACKS;
    localparam int CFG_BITS = HS + VS + 2 * HV;
    localparam int CW       = $clog2(CFG_BITS + 2);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CFG_BITS-1:0] sh_q, sh_d;
    logic [CFG_BITS-1:0] act_q, act_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                accept;
    logic [HS-1:0]       ph;
    logic [VS-1:0]       pv;
    logic [HV-1:0]       ur;
    logic [HV-1:0]       ld;

    assign accept = cfg.cfg_valid & ready_q;
    assign ph     = act_q[CFG_BITS-1 -: HS];
    assign pv     = act_q[CFG_BITS-HS-1 -: VS];
    assign ur     = act_q[2*HV-1 -: HV];
    assign ld     = act_q[HV-1:0];

    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_done  = done_q;
    assign cfg.cfg_err   = err_q;
`ifdef CBLOCK_READBACK_EN
    assign cfg.cfg_so    = sh_q[CFG_BITS-1];
`else
    assign cfg.cfg_so    = 1'b0;
`endif

    // Next-state for the load FSM, shadow chain, frame counter and commit into ACT
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = accept ? {sh_q[CFG_BITS-2:0], cfg.cfg_si} : sh_q;
        act_d   = act_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (accept) begin
                err_d   = 1'b0;
                cnt_d   = CW'(1);
                state_d = cfg.cfg_last ? COMMIT : SHIFT;
            end
`ifdef CBLOCK_READBACK_EN
            else if (cfg.cfg_rb) begin
                sh_d = act_q;
            end
`endif
        end else if (state_q == SHIFT) begin
            if (accept) begin
                cnt_d   = (cnt_q == CW'(CFG_BITS + 1)) ? cnt_q : cnt_q + CW'(1);
                state_d = cfg.cfg_last ? COMMIT : SHIFT;
            end
        end else begin
            state_d = IDLE;
            if (cnt_q == CW'(CFG_BITS)) begin
                act_d  = sh_q;
                done_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        ready_d = (state_d != COMMIT);
    end

    // Register FSM state, chain, active config and handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            act_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            act_q   <= act_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Crosspoint routing straight from ACT; open paths drive 0
    always_comb begin
        right_o = '0;
        down_o  = '0;
        for (int h = 0; h < H_TRACKS; h++) begin
            right_o[h] = (&ph[h*SEGS +: SEGS]) & left_i[h];
            for (int v = 0; v < V_TRACKS; v++)
                right_o[h] = right_o[h] | (ur[h*V_TRACKS+v] & up_i[v]);
        end
        for (int v = 0; v < V_TRACKS; v++) begin
            down_o[v] = (&pv[v*SEGS +: SEGS]) & up_i[v];
            for (int h = 0; h < H_TRACKS; h++)
                down_o[v] = down_o[v] | (ld[v*H_TRACKS+h] & left_i[h]);
        end
    end
endmodule

// File: tb/tb_cblock_cfg.sv
// tb_cblock_cfg: scoreboard bench for cblock_cfg at default 3x3x3 geometry
module tb_cblock_cfg;
    typedef struct {
        logic        done;
        logic        err;
        logic [35:0] act;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] left_i, up_i, right_o, down_o;
    int         checks = 0;
    int         errors = 0;
    int         pend   = 0;
    exp_t       q[$];
    logic [35:0] mdl_act;

    cblock_cfg_if cfg ();

    cblock_cfg dut (
        .clk     (clk),
        .rst     (rst),
        .left_i  (left_i),
        .up_i    (up_i),
        .right_o (right_o),
        .down_o  (down_o),
        .cfg     (cfg.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // PH at act[35:27], PV at act[26:18], UR at act[17:9], LD at act[8:0]
    function automatic logic [5:0] route(input logic [35:0] a, input logic [2:0] l, input logic [2:0] u);
        logic [2:0] r, d;
        for (int h = 0; h < 3; h++) begin
            r[h] = a[27+h*3] & a[28+h*3] & a[29+h*3] & l[h];
            for (int v = 0; v < 3; v++) r[h] = r[h] | (a[9+h*3+v] & u[v]);
        end
        for (int v = 0; v < 3; v++) begin
            d[v] = a[18+v*3] & a[19+v*3] & a[20+v*3] & u[v];
            for (int h = 0; h < 3; h++) d[v] = d[v] | (a[v*3+h] & l[h]);
        end
        return {r, d};
    endfunction

    // Commit monitor: two negedges after the last bit is seen offered, compare against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                if (q.size() == 0) check("sb_underflow", 1, 0);
                else begin
                    e = q.pop_front();
                    check("commit_done", cfg.cfg_done, e.done);
                    check("commit_err", cfg.cfg_err, e.err);
                    check("commit_route", {right_o, down_o}, route(e.act, left_i, up_i));
                end
            end
        end
        if (cfg.cfg_valid && cfg.cfg_ready && cfg.cfg_last) pend = 2;
    end

    task automatic send_bits(input logic [63:0] v, input int n, input bit chk_so,
                             input logic [35:0] rbp, input bit chk_err_clr);
        logic [35:0] prev;
        logic        rdy;
        int          t;
        prev = mdl_act;
        if (n == 36) begin
            q.push_back('{done: 1'b1, err: 1'b0, act: v[35:0]});
            mdl_act = v[35:0];
        end else begin
            q.push_back('{done: 1'b0, err: 1'b1, act: mdl_act});
        end
        for (int i = n - 1; i >= 0; i--) begin
            cfg.cfg_valid = 1'b1;
            cfg.cfg_si    = v[i];
            cfg.cfg_last  = (i == 0);
            t = 0;
            do begin
                @(negedge clk);
                rdy = cfg.cfg_ready;
                if (chk_so && rdy) begin
                    check("rb_so", cfg.cfg_so, rbp[i]);
                    check("rb_route_hold", {right_o, down_o}, route(prev, left_i, up_i));
                end
                @(posedge clk);
                #1;
                t++;
            end while (!rdy && t < 20);
            if (!rdy) check("ready_timeout", 0, 1);
            if (chk_err_clr && i == n - 1) check("err_clear", cfg.cfg_err, 0);
            if (i == n - 6) begin
                cfg.cfg_valid = 1'b0;
                cfg.cfg_last  = 1'b1;
                @(posedge clk);
                #1;
                cfg.cfg_last = 1'b0;
            end
        end
        cfg.cfg_valid = 1'b0;
        cfg.cfg_last  = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("done_pulse", cfg.cfg_done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0] p1, p1b, p3, pr;
        p1  = 36'h0;
        p1[30] = 1'b1; p1[31] = 1'b1; p1[32] = 1'b1;
        p1b = p1;
        p1b[31] = 1'b0;
        p3  = 36'h0;
        p3[15] = 1'b1; p3[5] = 1'b1;
        pr  = p1 | p3 | 36'h9_0000_0000;
        mdl_act = '0;
        cfg.cfg_si = 1'b0; cfg.cfg_valid = 1'b0; cfg.cfg_last = 1'b0; cfg.cfg_rb = 1'b0;
        rst = 1'b1; left_i = 3'b111; up_i = 3'b111;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_right", right_o, 3'b000);
        check("rst_down", down_o, 3'b000);
        check("rst_ready", cfg.cfg_ready, 1'b1);
        check("rst_done", cfg.cfg_done, 1'b0);
        check("rst_err", cfg.cfg_err, 1'b0);
        check("rst_so", cfg.cfg_so, 1'b0);
        @(posedge clk); #1;

        left_i = 3'b010; up_i = 3'b000;
        send_bits(p1, 36, 0, '0, 0);
        settle();
        check("ph_right", right_o, 3'b010);
        check("ph_down", down_o, 3'b000);
        send_bits(p1b, 36, 0, '0, 0);
        settle();
        check("ph_open_right", right_o, 3'b000);

        left_i = 3'b100; up_i = 3'b001;
        send_bits(p3, 36, 0, '0, 0);
        settle();
        check("x_right", right_o, 3'b100);
        check("x_down", down_o, 3'b010);

        send_bits({$urandom, $urandom}, 35, 0, '0, 0);
        settle();
        check("short_err", cfg.cfg_err, 1'b1);
        check("short_right", right_o, 3'b100);
        send_bits({$urandom, $urandom}, 40, 0, '0, 0);
        settle();
        check("long_err", cfg.cfg_err, 1'b1);
        check("long_down", down_o, 3'b010);
        send_bits(p3, 36, 0, '0, 1);
        settle();
        check("recover_err", cfg.cfg_err, 1'b0);

        left_i = 3'b111; up_i = 3'b111;
        for (int i = 0; i < 20; i++) begin
            cfg.cfg_valid = 1'b1;
            cfg.cfg_si    = 1'($urandom);
            @(posedge clk); #1;
        end
        cfg.cfg_valid = 1'b0;
        check("pre_rst_route", {right_o, down_o}, route(p3, 3'b111, 3'b111));
        #2 rst = 1'b1;
        #1;
        check("async_rst_right", right_o, 3'b000);
        check("async_rst_down", down_o, 3'b000);
        mdl_act = '0;
        @(posedge clk); #1 rst = 1'b0;
        send_bits(p1, 36, 0, '0, 0);
        settle();
        check("post_rst_right", right_o, 3'b010);

        send_bits(pr, 36, 0, '0, 0);
        settle();
        cfg.cfg_rb = 1'b1;
        @(posedge clk); #1;
        cfg.cfg_rb = 1'b0;
`ifdef CBLOCK_READBACK_EN
        send_bits(64'h0, 36, 1, pr, 0);
`else
        check("no_rb_so", cfg.cfg_so, 1'b0);
        send_bits(64'h0, 36, 0, '0, 0);
        check("no_rb_so_after", cfg.cfg_so, 1'b0);
`endif
        settle();
        check("zero_right", right_o, 3'b000);
        check("zero_down", down_o, 3'b000);
        check("sb_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
